// File: rtl/blit_gpu_rdresp.sv
// blit_gpu_rdresp: answers GPU reads to the blitter register window.
// A read is latched, its register snapshot is taken on a cycle where the
// blitter is not updating its pointers (or forcibly after a stall limit),
// and the data is returned with a single-cycle acknowledge.
module blit_gpu_rdresp #(
  parameter int unsigned STALL_MAX = 15
) (
  input  logic        sys_clk,
  input  logic        reset,
  input  logic [23:0] gpu_addr,
  input  logic        gpu_memr,
  input  logic        bliten,
  input  logic [15:0] a1_x,
  input  logic [15:0] a1_y,
  input  logic [15:0] a1_fx,
  input  logic [15:0] a1_fy,
  input  logic [15:0] a2_x,
  input  logic [15:0] a2_y,
  input  logic [15:0] icount,
  input  logic [15:0] stat,
  input  logic        ptr_upd,
  output logic [31:0] gpu_dout,
  output logic        gpu_ack,
  output logic        rd_busy,
  output logic        rd_forced
);

  localparam int unsigned SEL_W   = 5;
  localparam int unsigned STALL_W = 4;
  localparam int unsigned DATA_W  = 32;

  // Stall limit reduced to the counter width.
  localparam logic [STALL_W-1:0] STALL_LIM = STALL_W'(STALL_MAX);

  // Register offsets (gpu_addr[6:2]) of the readable blitter registers.
  localparam logic [SEL_W-1:0] SEL_STATUS = 5'b011_10;
  localparam logic [SEL_W-1:0] SEL_A1_PTR = 5'b000_01;
  localparam logic [SEL_W-1:0] SEL_A1_FRC = 5'b001_10;
  localparam logic [SEL_W-1:0] SEL_A2_PTR = 5'b010_11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAPT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SEL_W-1:0]    r_sel;
  logic [SEL_W-1:0]    w_sel_nxt;
  logic [STALL_W-1:0]  r_stall;
  logic [STALL_W-1:0]  w_stall_nxt;
  logic [DATA_W-1:0]   r_dout;
  logic [DATA_W-1:0]   w_dout_nxt;
  logic                r_ack;
  logic                w_ack_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                r_forced;
  logic                w_forced_nxt;
  logic                w_accept;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_unused_addr;

  // Only the register offset bits of the address are meaningful here.
  assign w_unused_addr = ^{gpu_addr[23:7], gpu_addr[1:0]};

  // New read accepted only when the window is selected and no read is pending.
  assign w_accept = gpu_memr & bliten & ~r_busy;

  // Live decode of the selected register; both halves come from the same edge.
  always_comb begin
    w_rd_data = '0;
    case (r_sel)
      SEL_STATUS: w_rd_data = {icount, stat};
      SEL_A1_PTR: w_rd_data = {a1_y, a1_x};
      SEL_A1_FRC: w_rd_data = {a1_fy, a1_fx};
      SEL_A2_PTR: w_rd_data = {a2_y, a2_x};
      default:    w_rd_data = '0;
    endcase
  end

  // Next-state and next-output logic of the read sequencer.
  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_stall_nxt  = r_stall;
    w_dout_nxt   = r_dout;
    w_forced_nxt = r_forced;
    case (r_state)
      ST_IDLE: begin
        w_stall_nxt = '0;
        if (w_accept) begin
          w_sel_nxt   = gpu_addr[6:2];
          w_state_nxt = ST_CAPT;
        end
      end
      ST_CAPT: begin
        if (!ptr_upd) begin
          w_dout_nxt  = w_rd_data;
          w_state_nxt = ST_ACK;
        end else if (r_stall == STALL_LIM) begin
          // Blitter never went quiet: take the snapshot anyway and flag it.
          w_dout_nxt   = w_rd_data;
          w_forced_nxt = 1'b1;
          w_state_nxt  = ST_ACK;
        end else begin
          w_stall_nxt = r_stall + STALL_W'(1);
        end
      end
      ST_ACK: begin
        w_stall_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_stall_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_ack_nxt  = (w_state_nxt == ST_ACK);
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_stall  <= '0;
      r_dout   <= '0;
      r_ack    <= 1'b0;
      r_busy   <= 1'b0;
      r_forced <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_stall  <= w_stall_nxt;
      r_dout   <= w_dout_nxt;
      r_ack    <= w_ack_nxt;
      r_busy   <= w_busy_nxt;
      r_forced <= w_forced_nxt;
    end
  end

  assign gpu_dout  = r_dout;
  assign gpu_ack   = r_ack;
  assign rd_busy   = r_busy;
  assign rd_forced = r_forced;

endmodule

// File: tb/tb_blit_gpu_rdresp.sv
// tb_blit_gpu_rdresp: directed scenarios plus randomized traffic, checked
// against a transaction-level reference model of the read responder.
module tb_blit_gpu_rdresp;

  localparam int unsigned STALL_MAX = 15;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic [23:0] gpu_addr;
  logic        gpu_memr;
  logic        bliten;
  logic [15:0] a1_x, a1_y, a1_fx, a1_fy, a2_x, a2_y, icount, stat;
  logic        ptr_upd;
  logic [31:0] gpu_dout;
  logic        gpu_ack;
  logic        rd_busy;
  logic        rd_forced;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acks   = 0;

  // Reference model state: one outstanding read at most.
  bit          m_pending = 1'b0;
  int          m_req_cyc = 0;
  logic [6:0]  m_off     = '0;
  int          m_ack_cyc = -1;
  logic [31:0] m_dout    = '0;
  bit          m_forced  = 1'b0;

  blit_gpu_rdresp #(.STALL_MAX(STALL_MAX)) dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .gpu_addr (gpu_addr),
    .gpu_memr (gpu_memr),
    .bliten   (bliten),
    .a1_x     (a1_x),
    .a1_y     (a1_y),
    .a1_fx    (a1_fx),
    .a1_fy    (a1_fy),
    .a2_x     (a2_x),
    .a2_y     (a2_y),
    .icount   (icount),
    .stat     (stat),
    .ptr_upd  (ptr_upd),
    .gpu_dout (gpu_dout),
    .gpu_ack  (gpu_ack),
    .rd_busy  (rd_busy),
    .rd_forced(rd_forced)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Register contents by GPU byte address, as seen by the read port.
  function automatic logic [31:0] ref_data(input logic [6:0] off);
    logic [6:0] w;
    w = {off[6:2], 2'b00};
    case (w)
      7'h38:   return {icount, stat};
      7'h04:   return {a1_y, a1_x};
      7'h18:   return {a1_fy, a1_fx};
      7'h2C:   return {a2_y, a2_x};
      default: return 32'h0;
    endcase
  endfunction

  // One clock: compare this cycle's outputs with the model, advance the model.
  task automatic tick();
    bit exp_ack;
    @(negedge sys_clk);
    exp_ack = (m_ack_cyc == cyc);
    check("m_ack",    32'(gpu_ack),   32'(exp_ack));
    check("m_busy",   32'(rd_busy),   32'(m_pending | exp_ack));
    check("m_forced", 32'(rd_forced), 32'(m_forced));
    check("m_dout",   gpu_dout,       m_dout);
    if (gpu_ack === 1'b1) n_acks++;
    if (reset) begin
      m_pending = 1'b0;
      m_ack_cyc = -1;
      m_dout    = '0;
      m_forced  = 1'b0;
    end else if (m_pending) begin
      if (!ptr_upd || (cyc - m_req_cyc - 1) == int'(STALL_MAX)) begin
        m_dout    = ref_data(m_off);
        m_forced  = m_forced | ptr_upd;
        m_ack_cyc = cyc + 1;
        m_pending = 1'b0;
      end
    end else if (!exp_ack && gpu_memr && bliten) begin
      m_pending = 1'b1;
      m_req_cyc = cyc;
      m_off     = gpu_addr[6:0];
    end
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic request(input logic [23:0] a);
    gpu_addr = a;
    gpu_memr = 1'b1;
    bliten   = 1'b1;
  endtask

  initial begin
    int nb;
    int w;
    int p;
    reset    = 1'b1;
    gpu_addr = '0;
    gpu_memr = 1'b0;
    bliten   = 1'b0;
    a1_x = '0; a1_y = '0; a1_fx = '0; a1_fy = '0;
    a2_x = '0; a2_y = '0; icount = '0; stat = '0;
    ptr_upd  = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_dout",   gpu_dout, 32'h0);
    check("rst_ack",    32'(gpu_ack), 32'h0);
    check("rst_busy",   32'(rd_busy), 32'h0);
    check("rst_forced", 32'(rd_forced), 32'h0);
    tick();

    // Status read, minimum latency
    icount = 16'h0123; stat = 16'h0001;
    request(24'hF02238);
    tick();
    gpu_memr = 1'b0;
    check("st_ack_n1", 32'(gpu_ack), 32'h0);
    tick();
    check("st_ack_n2", 32'(gpu_ack), 32'h1);
    check("st_dout",   gpu_dout, 32'h0123_0001);
    tick();
    check("st_ack_n3", 32'(gpu_ack), 32'h0);
    tick();

    // A1 read stalled while pointers move
    a1_x = 16'd5; a1_y = 16'd7;
    request(24'hF02204);
    tick();
    gpu_memr = 1'b0; ptr_upd = 1'b1;
    tick();
    a1_x = 16'd6; a1_y = 16'd8;
    tick();
    tick();
    ptr_upd = 1'b0;
    check("a1_ack_n4", 32'(gpu_ack), 32'h0);
    tick();
    check("a1_ack_n5", 32'(gpu_ack), 32'h1);
    check("a1_dout",   gpu_dout, 32'h0008_0006);
    tick();

    // Stall timeout forces the capture
    a2_x = 16'h1234; a2_y = 16'hABCD;
    request(24'hF0222C);
    ptr_upd = 1'b1;
    tick();
    gpu_memr = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      check("to_noack", 32'(gpu_ack), 32'h0);
      tick();
    end
    check("to_ack_n17", 32'(gpu_ack), 32'h1);
    check("to_forced",  32'(rd_forced), 32'h1);
    check("to_dout",    gpu_dout, 32'hABCD_1234);
    ptr_upd = 1'b0;
    tick();
    tick();
    check("to_sticky",  32'(rd_forced), 32'h1);

    // Unmapped read, dropped busy request, ignored unselected request
    nb = n_acks;
    request(24'hF0220C);
    tick();
    request(24'hF02238);
    tick();
    gpu_memr = 1'b0;
    check("um_ack",  32'(gpu_ack), 32'h1);
    check("um_dout", gpu_dout, 32'h0);
    tick();
    gpu_memr = 1'b1; bliten = 1'b0; gpu_addr = 24'hF02238;
    tick();
    gpu_memr = 1'b0;
    repeat (5) tick();
    check("um_one_ack", 32'(n_acks - nb), 32'h1);

    // Reset during capture
    nb = n_acks;
    request(24'hF02204);
    tick();
    gpu_memr = 1'b0; ptr_upd = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; ptr_upd = 1'b0;
    check("rr_busy",   32'(rd_busy), 32'h0);
    check("rr_dout",   gpu_dout, 32'h0);
    check("rr_forced", 32'(rd_forced), 32'h0);
    repeat (4) tick();
    check("rr_no_ack", 32'(n_acks - nb), 32'h0);

    // Back-to-back reads
    a1_fx = 16'h55AA; a1_fy = 16'h1357; icount = 16'h0F0F; stat = 16'h0002;
    request(24'hF02218);
    tick();
    gpu_memr = 1'b0;
    tick();
    check("bb_ack1",  32'(gpu_ack), 32'h1);
    check("bb_dout1", gpu_dout, 32'h1357_55AA);
    tick();
    w = 0;
    while (rd_busy === 1'b1 && w < 10) begin
      tick();
      w++;
    end
    check("bb_idle_n3", 32'(w), 32'h0);
    request(24'hF02238);
    tick();
    gpu_memr = 1'b0;
    tick();
    check("bb_ack2",  32'(gpu_ack), 32'h1);
    check("bb_dout2", gpu_dout, 32'h0F0F_0002);
    tick();

    // Randomized traffic against the model
    p = 10;
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        case ($urandom_range(0, 2))
          0:       p = 10;
          1:       p = 50;
          default: p = 97;
        endcase
      end
      gpu_memr = ($urandom_range(0, 2) == 0);
      bliten   = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 4))
        0: gpu_addr = {$urandom_range(0, 131071), 7'h04};
        1: gpu_addr = {17'h1E044, 7'h18};
        2: gpu_addr = {17'h1E044, 7'h2C};
        3: gpu_addr = {17'h1E044, 7'h38};
        default: gpu_addr = 24'($urandom);
      endcase
      ptr_upd = ($urandom_range(0, 99) < p);
      reset   = ($urandom_range(0, 299) == 0);
      a1_x   = 16'($urandom); a1_y  = 16'($urandom);
      a1_fx  = 16'($urandom); a1_fy = 16'($urandom);
      a2_x   = 16'($urandom); a2_y  = 16'($urandom);
      icount = 16'($urandom); stat  = 16'($urandom);
      tick();
    end
    reset = 1'b0; gpu_memr = 1'b0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/blit_gpu_rdresp.md
# blit_gpu_rdresp

GPU-bus read responder for the blitter register window. Accepts GPU read cycles to the blitter, snapshots the addressed read-only register coherently with the blitter's own pointer updates, and returns 32-bit data with a one-cycle acknowledge. It sits in the read direction opposite the blitter write-strobe decoder: the decoder generates load strobes for GPU writes, and this block answers GPU reads.

## Interface
Parameters:
- `STALL_MAX`, default 15: maximum number of capture-stall cycles before the snapshot is forced.

Ports:
- `sys_clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `gpu_addr`  in  24  GPU byte address; only [6:2] are decoded.
- `gpu_memr`  in  1  single-cycle GPU read request.
- `bliten`  in  1  blitter register window select.
- `a1_x`, `a1_y`  in  16 each  A1 pointer integer parts.
- `a1_fx`, `a1_fy`  in  16 each  A1 pointer fraction parts.
- `a2_x`, `a2_y`  in  16 each  A2 pointer integer parts.
- `icount`  in  16  live inner counter.
- `stat`  in  16  blitter status bits: bit0 idle, bit1 stopped.
- `ptr_upd`  in  1  the blitter is writing pointer/counter registers this cycle.
- `gpu_dout`  out  32  read data, valid while `gpu_ack`=1.
- `gpu_ack`  out  1  one-cycle read acknowledge.
- `rd_busy`  out  1  a request is in flight; the GPU must not issue another read.
- `rd_forced`  out  1  sticky flag: a capture was forced by a stall timeout. Cleared by reset only.

## Operation
- Accept a request when `gpu_memr & bliten & ~rd_busy`. Latch `gpu_addr[6:2]` into `sel`.
- A request that arrives while `rd_busy`=1 is dropped. No ack is produced for it.
- Decode of `sel`. These are the bug-compatible addresses:
  - 5'b011_10 (F02238) → `{icount, stat}`.
  - 5'b000_01 (F02204) → `{a1_y, a1_x}`.
  - 5'b001_10 (F02218) → `{a1_fy, a1_fx}`.
  - 5'b010_11 (F0222C) → `{a2_y, a2_x}`.
  - Any other offset → 32'h0000_0000, still acknowledged.
- State machine:
  - IDLE → CAPT on an accepted request.
  - CAPT: if `ptr_upd`=0, load the decoded data into the `gpu_dout` register and go to ACK. If `ptr_upd`=1, increment a 4-bit stall counter and stay.
  - CAPT, forced capture: when the stall counter reaches `STALL_MAX` and `ptr_upd` is still 1, capture anyway, set `rd_forced`, and go to ACK.
  - ACK: assert `gpu_ack` for one cycle, then go to IDLE. Clear the stall counter.
- Coherence: both 16-bit halves are sampled on the same edge, so a read never mixes a pre-update X with a post-update Y.
- `gpu_dout` holds its last captured value after ACK until the next capture.
- `rd_busy` = (state != IDLE).
- `gpu_memr` with `bliten`=0 is ignored completely.

## Timing
- Reset values: state=IDLE, `gpu_dout`=0, `gpu_ack`=0, `rd_busy`=0, `rd_forced`=0, stall counter=0.
- Reset asserted mid-operation: return to IDLE on the next edge. The pending ack is lost and no ack is emitted.
- Minimum latency:
  - Request in cycle N.
  - CAPT in N+1; data sampled at the end of N+1.
  - `gpu_ack`=1 with valid `gpu_dout` in N+2.
- With k stall cycles, ack lands in N+2+k, where k ≤ `STALL_MAX`.
- A forced capture with `STALL_MAX`=15 acks in N+17.
- A new request is accepted no earlier than the cycle after ACK (back-to-back rate: one read per 3 cycles).
- `ptr_upd` sampled in ACK or IDLE has no effect.

## Test plan
- Status read:
  - Stimulus: `gpu_addr`=F02238, `icount`=16'h0123, `stat`=16'h0001, `gpu_memr` pulse at N.
  - Required: `gpu_ack`=1 at N+2 only; `gpu_dout`=32'h0123_0001.
- A1 read with stall:
  - Stimulus: F02204, `ptr_upd`=1 for cycles N+1..N+3. `a1_x`/`a1_y` change from 5/7 to 6/8 during the stall.
  - Required: ack at N+5; `gpu_dout`=32'h0008_0006.
- Timeout:
  - Stimulus: F0222C with `ptr_upd` held at 1.
  - Required: ack at N+17; `rd_forced`=1 and stays 1 afterwards.
- Unmapped and busy:
  - Stimulus: read F0220C, which returns 0 and acks at N+2. A second `gpu_memr` at N+1 is dropped. A `gpu_memr` with `bliten`=0 gets no response.
  - Required: exactly one ack for the sequence.
- Reset mid-read:
  - Stimulus: assert `reset` during CAPT.
  - Required: no ack follows; `gpu_dout`=0; `rd_busy`=0 on the next cycle.
- Back-to-back:
  - Stimulus: F02218 then F02238, each issued as soon as `rd_busy`=0.
  - Required: acks at N+2 and N+5 with the correct data each time.
